// File: rtl/carry_resolve_stream_pkg.sv
// Shared types and constants for the carry-resolving byte stream.
package carry_resolve_stream_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  localparam logic [7:0] BYTE_FF   = 8'hFF;
  localparam int         CARRY_BIT = 8;

endpackage

// File: rtl/sync_byte_fifo.sv
// Register-based synchronous FIFO; a write becomes visible on the read side one cycle later.
module sync_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             can_push_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o    = (count_q != '0);
  assign do_pop     = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign can_push_o = (count_q != FULL_CNT) || do_pop;
  assign do_push    = push_i && can_push_o;
  assign data_o     = valid_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/carry_resolve_stream.sv
// Resolves arithmetic-coder carries: holds one byte plus a run of pending 0xFF bytes
// until a later word decides whether the carry ripples through them.
module carry_resolve_stream
  import carry_resolve_stream_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int RUN_WIDTH  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_word,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_byte,
  output logic                out_last,
  output logic                err
);

  localparam logic [RUN_WIDTH-1:0] CNT_ONE = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [RUN_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           hold_q, hold_d;
  logic [7:0]           head_q, head_d;
  logic [7:0]           run_byte_q, run_byte_d;
  logic                 head_pend_q, head_pend_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic [CARRY_BIT:0]   w;
  logic                 upper_set;
  logic                 push;
  logic                 push_last;
  logic [7:0]           push_byte;
  logic                 can_push;
  logic                 write_done;
  logic [8:0]           fifo_q;

  assign in_ready  = ((state_q == ST_EMPTY) || (state_q == ST_HOLD)) && !reset;
  assign accept    = in_valid && in_ready;
  assign w         = in_word[CARRY_BIT:0];
  assign upper_set = |(in_word >> (CARRY_BIT + 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    head_d      = head_q;
    run_byte_d  = run_byte_q;
    head_pend_d = head_pend_q;
    last_d      = last_q;
    err_d       = err_q;
    push        = 1'b0;
    push_last   = 1'b0;
    push_byte   = 8'h00;
    write_done  = 1'b0;

    if (accept && upper_set) err_d = 1'b1;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          hold_d = w[7:0];
          cnt_d  = '0;
          if (w[CARRY_BIT]) err_d = 1'b1;
          if (in_last) begin
            state_d     = ST_FLUSH;
            head_pend_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (w == {1'b0, BYTE_FF}) begin
            if (cnt_q == CNT_MAX) err_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
            if (in_last) begin
              state_d     = ST_FLUSH;
              head_pend_d = 1'b1;
            end
          end else begin
            // A carry bumps the held byte and turns the pending 0xFF run into zeros.
            head_d      = w[CARRY_BIT] ? hold_q + 8'd1 : hold_q;
            run_byte_d  = w[CARRY_BIT] ? 8'h00 : BYTE_FF;
            if (w[CARRY_BIT] && (hold_q == BYTE_FF)) err_d = 1'b1;
            hold_d      = w[7:0];
            last_d      = in_last;
            head_pend_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN, ST_FLUSH: begin
        if (can_push) begin
          push = 1'b1;
          if (head_pend_q) begin
            push_byte   = (state_q == ST_DRAIN) ? head_q : hold_q;
            head_pend_d = 1'b0;
            write_done  = (cnt_q == '0);
          end else begin
            push_byte  = (state_q == ST_DRAIN) ? run_byte_q : BYTE_FF;
            cnt_d      = cnt_q - CNT_ONE;
            write_done = (cnt_q == CNT_ONE);
          end
          if (write_done) begin
            if (state_q == ST_FLUSH) begin
              push_last = 1'b1;
              last_d    = 1'b0;
              cnt_d     = '0;
              state_d   = ST_EMPTY;
            end else if (last_q) begin
              state_d     = ST_FLUSH;
              head_pend_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      hold_q      <= '0;
      head_pend_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      head_pend_q <= head_pend_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q     <= head_d;
    run_byte_q <= run_byte_d;
  end

  sync_byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .data_i     ({push_last, push_byte}),
    .pop_i      (out_ready),
    .valid_o    (out_valid),
    .can_push_o (can_push),
    .data_o     (fifo_q)
  );

  assign out_byte = fifo_q[7:0];
  assign out_last = fifo_q[8];
  assign err      = err_q;

endmodule

// File: doc/carry_resolve_stream.md
CARRY_RESOLVE_STREAM -- requirements
Module: carry_resolve_stream

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - IN_WIDTH, 16, precarry word width; minimum 9.
  - RUN_WIDTH, 12, width of the pending-0xFF run counter.
  - FIFO_DEPTH, 8, output byte FIFO entries; power of two, minimum 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high.
  - in_valid  in  1  in_word is offered.
  - in_ready  out  1  block accepts in_word this cycle.
  - in_word  in  IN_WIDTH  precarry word; bit 8 is the carry.
  - in_last  in  1  final word of the frame; qualified by in_valid.
  - out_valid  out  1  out_byte is valid.
  - out_ready  in  1  sink takes out_byte.
  - out_byte  out  8  resolved bitstream byte.
  - out_last  out  1  final byte of the frame.
  - err  out  1  sticky error flag.
REQ-003 The block has one clock. Reset is synchronous and active-high, on ports clk and reset.

Function
REQ-004 A word transfers when in_valid && in_ready. A byte transfers when out_valid && out_ready.
REQ-005 States: EMPTY (no byte held), HOLD (byte hold plus run count cnt of pending 0xFF), DRAIN, FLUSH.
REQ-006 in_ready is 1 only in EMPTY or HOLD.
REQ-007 EMPTY, word w accepted: hold=w[7:0], cnt=0, go to HOLD.
  - If w[8]=1, set err.
REQ-008 HOLD, w==0x0FF: cnt+=1 and stay in HOLD; nothing is emitted.
  - If cnt is at its maximum, cnt saturates and err is set.
REQ-009 HOLD, w<0x0FF: queue hold, then cnt bytes of 0xFF.
  - Then hold=w[7:0], go to DRAIN.
REQ-010 HOLD, w[8]=1: queue (hold+1) mod 256, then cnt bytes of 0x00.
  - Then hold=w[7:0], go to DRAIN.
  - If hold==0xFF, set err (carry past stream start).
REQ-011 Any set bit of w above bit 8 sets err; the word is otherwise treated as w[8:0].
REQ-012 DRAIN writes one byte per cycle into the FIFO, only when the FIFO is not full.
  - The first write is the queued head byte, then the run bytes.
  - After the last write: go to FLUSH if in_last was latched, else to HOLD.
REQ-013 FLUSH: write hold, then cnt bytes of 0xFF; the final byte written carries out_last=1.
  - Then clear the latched last flag and cnt, and go to EMPTY.
REQ-014 in_last on a word accepted in EMPTY, or on a 0x0FF word accepted in HOLD, goes directly to FLUSH.
REQ-015 Byte order out equals write order. Every accepted frame produces exactly (accepted words) bytes, counting run bytes.
REQ-016 FIFO: a byte written in cycle t is visible on out_valid at t+1 at the earliest.
  - When full, DRAIN/FLUSH stall and hold their position.
  - Simultaneous push and pop while full is allowed.
REQ-017 Minimum latency: word accepted at t produces first resolved byte on out_byte at t+2.
REQ-018 err clears only on reset.

Reset
REQ-019 On reset, all of the following are cleared and the state goes to EMPTY:
  - FIFO emptied: out_valid=0, out_byte=0, out_last=0.
  - in_ready=0 during the reset cycle, 1 on the following cycle.
  - cnt=0, hold=0, err=0, last flag=0.
REQ-020 Reset mid-DRAIN or mid-FLUSH discards all pending bytes; no partial frame is emitted afterwards.

Structure
REQ-021 A shared package holds the state enumeration and the constants BYTE_FF=8'hFF and CARRY_BIT=8.
REQ-022 The output FIFO is the sub-module sync_byte_fifo (width 9: byte plus last, depth FIFO_DEPTH); all other logic stays in carry_resolve_stream.

Verification
REQ-023 Words 0x012, 0x034, last 0x056, out_ready=1 -> bytes 12, 34, 56; out_last only on 56; err=0.
REQ-024 Words 0x07F, 0x0FF, 0x0FF, 0x100, last 0x010 -> bytes 80, 00, 00, 00, 10.
REQ-025 Words 0x07F, 0x0FF x3, 0x020, last 0x030 -> bytes 7F, FF, FF, FF, 20, 30; in_ready low during drain.
REQ-026 FIFO_DEPTH=2, out_ready held low for 10 cycles during a 5-byte drain -> no loss, no duplication, order preserved after release.
REQ-027 First word 0x1AB -> err=1, first byte AB. With RUN_WIDTH=2 and five 0x0FF words -> err=1.
REQ-028 reset asserted mid-DRAIN -> next cycle out_valid=0, err=0; a new frame 0x001 (last) -> single byte 01 with out_last.
